// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the EX-stage HI/LO mult/div sequencer.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  // Bit positions in the one-hot op select, in hilo_op field order.
  localparam int OP_MULT  = 0;
  localparam int OP_MULTU = 1;
  localparam int OP_DIV   = 2;
  localparam int OP_DIVU  = 3;
  localparam int OP_W     = 4;

  localparam int MUL_LAT_DEF = 2;
  localparam int WORD_W      = 32;
  localparam int RES_W       = 64;

  // {remainder, quotient} reported for a zero divisor: rem = dividend, quot = all ones.
  function automatic logic [RES_W-1:0] zero_div_result(input logic [WORD_W-1:0] dividend);
    return {dividend, {WORD_W{1'b1}}};
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencer for mult/multu/div/divu: drives the multiplier/divider, stalls EX, holds {hi,lo}.
// Optional MULDIV_DIVZERO_BYPASS_EN: zero-divisor divides complete without starting the divider.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall_in,
  input  logic        op_valid,
  input  logic        op_mult,
  input  logic        op_multu,
  input  logic        op_div,
  input  logic        op_divu,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        stallreq,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  input  logic        div_ready,
  input  logic [63:0] div_result
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [31:0]        r_opa;
  logic [31:0]        r_opb;
  logic               r_sgn;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;

  logic [OP_W-1:0]    w_op_sel;
  logic               w_is_mul;
  logic               w_accept;
  logic               w_div_zero;
  logic               w_in_mul;
  logic               w_in_div;
  logic               w_cap_mul;
  logic               w_cap_div;
  logic               w_cap_zero;

  assign w_op_sel[OP_MULT]  = op_mult;
  assign w_op_sel[OP_MULTU] = op_multu;
  assign w_op_sel[OP_DIV]   = op_div;
  assign w_op_sel[OP_DIVU]  = op_divu;

  assign w_is_mul = w_op_sel[OP_MULT] | w_op_sel[OP_MULTU];
  assign w_accept = op_valid & (|w_op_sel) & ~flush;

`ifdef MULDIV_DIVZERO_BYPASS_EN
  assign w_div_zero = ~w_is_mul & (opb == '0);
`else
  assign w_div_zero = 1'b0;
`endif

  assign w_in_mul = (r_state == ST_MUL_WAIT);
  assign w_in_div = (r_state == ST_DIV_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cap_mul    = 1'b0;
    w_cap_div    = 1'b0;
    w_cap_zero   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_is_mul) begin
            w_state_next = ST_MUL_WAIT;
            w_cnt_next   = CNT_W'(MUL_LAT);
          end else if (w_div_zero) begin
            w_state_next = ST_DONE;
            w_cap_zero   = 1'b1;
          end else begin
            w_state_next = ST_DIV_WAIT;
          end
        end
      end
      ST_MUL_WAIT: begin
        if (r_cnt == '0) begin
          w_state_next = ST_DONE;
          w_cap_mul    = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      ST_DIV_WAIT: begin
        if (div_ready) begin
          w_state_next = ST_DONE;
          w_cap_div    = 1'b1;
        end
      end
      ST_DONE: begin
        if (!stall_in) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
    // A flush discards whatever is in flight, including a result arriving this cycle.
    if (flush) begin
      w_state_next = ST_IDLE;
      w_cnt_next   = '0;
      w_cap_mul    = 1'b0;
      w_cap_div    = 1'b0;
      w_cap_zero   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_opa <= '0;
      r_opb <= '0;
      r_sgn <= 1'b0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      if (r_state == ST_IDLE && w_accept) begin
        r_opa <= opa;
        r_opb <= opb;
        r_sgn <= w_op_sel[OP_MULT] | w_op_sel[OP_DIV];
      end
      if (w_cap_mul)  {r_hi, r_lo} <= mul_result;
      if (w_cap_div)  {r_hi, r_lo} <= div_result;
      if (w_cap_zero) {r_hi, r_lo} <= zero_div_result(opa);
    end
  end

  // Handshakes are gated by rst so a mid-operation reset never pulses start or annul.
  assign stallreq   = ~rst & ~flush & (((r_state == ST_IDLE) & w_accept) | w_in_mul | w_in_div);
  assign hi_we      = ~rst & ~flush & (r_state == ST_DONE);
  assign lo_we      = hi_we;
  assign hi_o       = r_hi;
  assign lo_o       = r_lo;

  assign mul_signed = w_in_mul & r_sgn;
  assign mul_ina    = w_in_mul ? r_opa : '0;
  assign mul_inb    = w_in_mul ? r_opb : '0;

  assign div_start  = ~rst & w_in_div & ~div_ready & ~flush;
  assign div_annul  = ~rst & w_in_div & flush;
  assign div_signed = w_in_div & r_sgn;
  assign div_opa    = w_in_div ? r_opa : '0;
  assign div_opb    = w_in_div ? r_opb : '0;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl with behavioural multiplier/divider models; honours MULDIV_DIVZERO_BYPASS_EN.
module tb_muldiv_ctrl;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst, flush, stall_in, op_valid;
  logic        op_mult, op_multu, op_div, op_divu;
  logic [31:0] opa, opb;
  logic        stallreq, hi_we, lo_we;
  logic [31:0] hi_o, lo_o;
  logic        mul_signed;
  logic [31:0] mul_ina, mul_inb;
  logic [63:0] mul_result;
  logic        div_start, div_signed, div_annul;
  logic [31:0] div_opa, div_opb;
  logic        div_ready;
  logic [63:0] div_result;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_in(stall_in), .op_valid(op_valid),
    .op_mult(op_mult), .op_multu(op_multu), .op_div(op_div), .op_divu(op_divu),
    .opa(opa), .opb(opb), .stallreq(stallreq), .hi_we(hi_we), .lo_we(lo_we),
    .hi_o(hi_o), .lo_o(lo_o), .mul_signed(mul_signed), .mul_ina(mul_ina),
    .mul_inb(mul_inb), .mul_result(mul_result), .div_start(div_start),
    .div_signed(div_signed), .div_annul(div_annul), .div_opa(div_opa),
    .div_opb(div_opb), .div_ready(div_ready), .div_result(div_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic [63:0] mul_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    p = sa * sb;
    return 64'(p);
  endfunction

  // {remainder, quotient}; zero divisor gives rem = dividend, quot = all ones
  function automatic logic [63:0] div_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Cycle (relative to the accept cycle) at which the result is first presented.
  function automatic int rel_done(input int kind, input logic [31:0] b, input int lat);
    if (kind < 2) return MUL_LAT + 2;
`ifdef MULDIV_DIVZERO_BYPASS_EN
    if (b == 32'd0) return 1;
`endif
    return lat + 2;
  endfunction

  // ---------------- multiplier model: result MUL_LAT cycles after inputs ----------------
  logic [63:0] mul_pipe [MUL_LAT];
  always @(posedge clk) begin
    mul_pipe[0] <= mul_ref(mul_signed, mul_ina, mul_inb);
    for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign mul_result = mul_pipe[MUL_LAT-1];

  // ---------------- divider model: ready div_lat cycles after first start ----------------
  int          div_lat = 1;
  logic        dm_busy;
  int          dm_cnt;
  logic [31:0] dm_a, dm_b;
  logic        dm_sgn;

  always @(posedge clk) begin
    if (rst || div_annul) begin
      dm_busy   <= 1'b0;
      div_ready <= 1'b0;
    end else if (div_ready) begin
      div_ready <= 1'b0;
    end else if (dm_busy) begin
      if (dm_cnt == 1) begin
        dm_busy    <= 1'b0;
        div_ready  <= 1'b1;
        div_result <= div_ref(dm_sgn, dm_a, dm_b);
      end
      dm_cnt <= dm_cnt - 1;
    end else if (div_start) begin
      dm_a   <= div_opa;
      dm_b   <= div_opb;
      dm_sgn <= div_signed;
      if (div_lat <= 1) begin
        div_ready  <= 1'b1;
        div_result <= div_ref(div_signed, div_opa, div_opb);
      end else begin
        dm_busy <= 1'b1;
        dm_cnt  <= div_lat - 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          done;
    int          stall_n;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] cur_a = '0, cur_b = '0;
  logic        cur_sgn = 1'b0;
  logic        allow_div = 1'b0;

  exp_t cur_exp;
  logic mon_active = 1'b0;
  logic prev_we = 1'b0;
  int   run_len = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (div_start && !dm_busy && !div_ready) begin
        chk("div_start_allowed", 64'(div_start), 64'(allow_div));
        chk("div_operands", {div_opa, div_opb}, {cur_a, cur_b});
        chk("div_signed", 64'(div_signed), 64'(cur_sgn));
      end
      if (div_ready) chk("div_start_at_ready", 64'(div_start), 64'd0);

      if (hi_we && !prev_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: hi_we=1 with no outstanding op (cycle %0d)", cyc);
          mon_active = 1'b0;
        end else begin
          cur_exp    = exp_q.pop_front();
          mon_active = 1'b1;
          run_len    = 0;
          chk("done_cycle", 64'(cyc), 64'(cur_exp.done));
        end
      end
      if (hi_we && mon_active) begin
        chk("result", {hi_o, lo_o}, {cur_exp.hi, cur_exp.lo});
        chk("lo_we", 64'(lo_we), 64'd1);
        run_len++;
      end
      if (!hi_we && prev_we && mon_active) begin
        chk("done_length", 64'(run_len), 64'(cur_exp.stall_n + 1));
        mon_active = 1'b0;
      end
      prev_we = hi_we;
    end
  end

  // ---------------- stimulus ----------------
  // kind: 0 mult, 1 multu, 2 div, 3 divu; flush_at < 0 means no flush.
  task automatic issue(input int kind, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input int stall_n, input int flush_at, input int gap);
    int          done, k, c;
    logic        sgn, is_mul, last;
    logic [63:0] res;
    exp_t        e;
    is_mul = (kind < 2);
    sgn    = (kind == 0) || (kind == 2);
    res    = is_mul ? mul_ref(sgn, a, b) : div_ref(sgn, a, b);
    done   = rel_done(kind, b, lat);
    div_lat   = lat;
    cur_a     = a;
    cur_b     = b;
    cur_sgn   = sgn;
    allow_div = !is_mul && (done != 1);
    c = cyc;
    if (flush_at < 0) begin
      e.done    = c + done;
      e.stall_n = stall_n;
      e.hi      = res[63:32];
      e.lo      = res[31:0];
      exp_q.push_back(e);
    end
    op_valid = 1'b1;
    op_mult  = (kind == 0);
    op_multu = (kind == 1);
    op_div   = (kind == 2);
    op_divu  = (kind == 3);
    opa = a;
    opb = b;
    k = 0;
    last = 1'b0;
    while (!last) begin
      flush    = (k == flush_at);
      stall_in = (flush_at < 0) && (k >= done) && (k < done + stall_n);
      @(negedge clk);
      chk("stallreq", 64'(stallreq), 64'((k < done) && (k != flush_at)));
      chk("div_start", 64'(div_start),
          64'(allow_div && (k >= 1) && (k <= lat) && (k != flush_at)));
      if (is_mul && k == 1) begin
        chk("mul_inputs", {mul_ina, mul_inb}, {a, b});
        chk("mul_signed", 64'(mul_signed), 64'(sgn));
      end
      if (k == flush_at) begin
        chk("flush_hi_we", 64'(hi_we), 64'd0);
        chk("div_annul", 64'(div_annul), 64'(allow_div && (k >= 1) && (k <= lat + 1)));
      end
      last = (flush_at >= 0) ? (k == flush_at) : (k == done + stall_n);
      @(posedge clk);
      #1;
      k++;
    end
    op_valid = 1'b0;
    op_mult  = 1'b0;
    op_multu = 1'b0;
    op_div   = 1'b0;
    op_divu  = 1'b0;
    flush    = 1'b0;
    stall_in = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      chk("idle_stallreq", 64'(stallreq), 64'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          kind, lat, stall_n, flush_at;
    logic [31:0] a, b;
    rst = 1'b1; flush = 1'b0; stall_in = 1'b0; op_valid = 1'b0;
    op_mult = 1'b0; op_multu = 1'b0; op_div = 1'b0; op_divu = 1'b0;
    opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_result", {hi_o, lo_o}, 64'd0);
    chk("reset_we", {62'd0, hi_we, lo_we}, 64'd0);
    chk("reset_stallreq", 64'(stallreq), 64'd0);
    chk("reset_div_ctl", {62'd0, div_start, div_annul}, 64'd0);
    chk("reset_mul_in", {mul_ina, mul_inb}, 64'd0);
    @(posedge clk);
    #1;

    issue(0, 32'hFFFF_FFFF, 32'd2, 1, 0, -1, 1);
    issue(1, 32'hFFFF_FFFF, 32'd2, 1, 0, -1, 1);
    issue(2, 32'hFFFF_FFF9, 32'd2, 32, 0, -1, 1);
    issue(3, 32'd12345678, 32'd99, 20, 0, 10, 1);
    issue(0, 32'h0001_0003, 32'hFFFF_FFFD, 1, 3, -1, 2);
    issue(3, 32'h0000_1234, 32'd0, 5, 0, -1, 1);
    issue(2, 32'h8000_0000, 32'hFFFF_FFFF, 3, 0, -1, 0);
    issue(1, 32'h1234_5678, 32'h9ABC_DEF0, 1, 1, -1, 0);

    // Reset in the middle of a divide: no annul pulse, outputs back to idle.
    div_lat = 20; cur_a = 32'd1000; cur_b = 32'd7; cur_sgn = 1'b0; allow_div = 1'b1;
    op_valid = 1'b1; op_divu = 1'b1; opa = 32'd1000; opb = 32'd7;
    @(posedge clk);
    #1;
    op_valid = 1'b0; op_divu = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_annul", 64'(div_annul), 64'd0);
    chk("rst_mid_stallreq", 64'(stallreq), 64'd0);
    chk("rst_mid_div_start", 64'(div_start), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_result", {hi_o, lo_o}, 64'd0);
    chk("post_rst_div_start", 64'(div_start), 64'd0);
    chk("post_rst_stallreq", 64'(stallreq), 64'd0);
    @(posedge clk);
    #1;

    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'($urandom_range(0, 3));
      if (kind >= 2 && $urandom_range(0, 5) == 0) b = 32'd0;
      if ((kind == 0 || kind == 2) && $urandom_range(0, 9) == 0) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      lat      = int'($urandom_range(1, 8));
      stall_n  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      flush_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, rel_done(kind, b, lat))) : -1;
      issue(kind, a, b, lat, stall_n, flush_at, int'($urandom_range(0, 2)));
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
